// File: rtl/pipe_alu_hazard_fwd.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : pipe_alu_hazard_fwd
// Description : 4-stage (D/X/M/W) integer pipeline with register file,
//               X/M operand forwarding and load-use / RAW hazard stalls.
// Revision    : 1.0 - initial release
// ============================================================================
module pipe_alu_hazard_fwd #(
   parameter int W      = 8,
   parameter int RW     = 5,
   parameter int CW     = 16,
   parameter bit FWD_EN = 1'b1
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [1:0]    in_op,
   input  logic          in_mem_read,
   input  logic          in_reg_write,
   input  logic [RW-1:0] in_rs,
   input  logic [RW-1:0] in_rt,
   input  logic [RW-1:0] in_rd,
   input  logic [W-1:0]  in_imm,
   output logic          out_valid,
   output logic [RW-1:0] out_rd,
   output logic [W-1:0]  out_data,
   output logic [CW-1:0] stall_cnt,
   output logic [CW-1:0] retire_cnt
);

   localparam int            NREG     = 1 << RW;
   localparam logic [CW-1:0] CNT_MAX  = '1;
   localparam logic [CW-1:0] CNT_ONE  = CW'(1);
   localparam logic [1:0]    OP_ADD   = 2'b00;
   localparam logic [1:0]    OP_SUB   = 2'b01;
   localparam logic [1:0]    OP_AND   = 2'b10;

   // D stage
   logic          d_valid_q, d_valid_d;
   logic [1:0]    d_op_q, d_op_d;
   logic          d_mem_read_q, d_mem_read_d;
   logic          d_reg_write_q, d_reg_write_d;
   logic [RW-1:0] d_rs_q, d_rs_d, d_rt_q, d_rt_d, d_rd_q, d_rd_d;
   logic [W-1:0]  d_imm_q, d_imm_d;
   // X stage
   logic          x_valid_q, x_valid_d;
   logic          x_load_q, x_load_d;
   logic          x_reg_write_q, x_reg_write_d;
   logic [RW-1:0] x_rd_q, x_rd_d;
   logic [W-1:0]  x_data_q, x_data_d;
   // M stage
   logic          m_valid_q, m_valid_d;
   logic          m_reg_write_q, m_reg_write_d;
   logic [RW-1:0] m_rd_q, m_rd_d;
   logic [W-1:0]  m_data_q, m_data_d;
   // W stage
   logic          wb_valid_q, wb_valid_d;
   logic [RW-1:0] wb_rd_q, wb_rd_d;
   logic [W-1:0]  wb_data_q, wb_data_d;

   logic [W-1:0]  rf_q [NREG];
   logic [W-1:0]  rf_d [NREG];
   logic [CW-1:0] stall_cnt_q, stall_cnt_d;
   logic [CW-1:0] retire_cnt_q, retire_cnt_d;

   logic          x_hit_rs, x_hit_rt, m_hit_rs, m_hit_rt;
   logic          hazard, stall;
   logic [W-1:0]  op_a, op_b, d_result;

   // Operand mux: youngest non-load producer in X, then M, then the register file.
   function automatic logic [W-1:0] pick(input logic x_fwd, input logic m_fwd,
                                         input logic [W-1:0] x_val,
                                         input logic [W-1:0] m_val,
                                         input logic [W-1:0] rf_val);
      if (FWD_EN && x_fwd)      return x_val;
      else if (FWD_EN && m_fwd) return m_val;
      else                      return rf_val;
   endfunction

   always_comb begin
      x_hit_rs = x_valid_q && x_reg_write_q && (x_rd_q == d_rs_q) && (d_rs_q != '0);
      x_hit_rt = x_valid_q && x_reg_write_q && (x_rd_q == d_rt_q) && (d_rt_q != '0);
      m_hit_rs = m_valid_q && m_reg_write_q && (m_rd_q == d_rs_q) && (d_rs_q != '0);
      m_hit_rt = m_valid_q && m_reg_write_q && (m_rd_q == d_rt_q) && (d_rt_q != '0);
      if (FWD_EN) hazard = x_load_q && (x_hit_rs || x_hit_rt);
      else        hazard = x_hit_rs || x_hit_rt || m_hit_rs || m_hit_rt;
      stall    = d_valid_q && hazard;
      in_ready = !stall;
   end

   always_comb begin
      op_a = pick(x_hit_rs && !x_load_q, m_hit_rs, x_data_q, m_data_q, rf_q[d_rs_q]);
      op_b = pick(x_hit_rt && !x_load_q, m_hit_rt, x_data_q, m_data_q, rf_q[d_rt_q]);
      case (d_op_q)
         OP_ADD:  d_result = op_a + op_b;
         OP_SUB:  d_result = op_a - op_b;
         OP_AND:  d_result = op_a & op_b;
         default: d_result = d_imm_q;
      endcase
      // Load data is modelled by the immediate but only becomes forwardable from M.
      if (d_mem_read_q) d_result = d_imm_q;
   end

   always_comb begin
      d_valid_d     = d_valid_q;
      d_op_d        = d_op_q;
      d_mem_read_d  = d_mem_read_q;
      d_reg_write_d = d_reg_write_q;
      d_rs_d        = d_rs_q;
      d_rt_d        = d_rt_q;
      d_rd_d        = d_rd_q;
      d_imm_d       = d_imm_q;
      if (in_ready) begin
         d_valid_d     = in_valid;
         d_op_d        = in_op;
         d_mem_read_d  = in_mem_read;
         d_reg_write_d = in_reg_write;
         d_rs_d        = in_rs;
         d_rt_d        = in_rt;
         d_rd_d        = in_rd;
         d_imm_d       = in_imm;
      end

      x_valid_d     = d_valid_q && !hazard;
      x_load_d      = d_mem_read_q;
      x_reg_write_d = d_reg_write_q;
      x_rd_d        = d_rd_q;
      x_data_d      = d_result;

      m_valid_d     = x_valid_q;
      m_reg_write_d = x_reg_write_q;
      m_rd_d        = x_rd_q;
      m_data_d      = x_data_q;

      wb_valid_d    = m_valid_q;
      wb_rd_d       = m_rd_q;
      wb_data_d     = m_data_q;

      rf_d = rf_q;
      if (m_valid_q && m_reg_write_q && (m_rd_q != '0)) rf_d[m_rd_q] = m_data_q;

      stall_cnt_d = stall_cnt_q;
      if (stall && (stall_cnt_q != CNT_MAX)) stall_cnt_d = stall_cnt_q + CNT_ONE;
      retire_cnt_d = retire_cnt_q;
      if (m_valid_q && (retire_cnt_q != CNT_MAX)) retire_cnt_d = retire_cnt_q + CNT_ONE;
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         d_valid_q     <= 1'b0;
         d_op_q        <= '0;
         d_mem_read_q  <= 1'b0;
         d_reg_write_q <= 1'b0;
         d_rs_q        <= '0;
         d_rt_q        <= '0;
         d_rd_q        <= '0;
         d_imm_q       <= '0;
         x_valid_q     <= 1'b0;
         x_load_q      <= 1'b0;
         x_reg_write_q <= 1'b0;
         x_rd_q        <= '0;
         x_data_q      <= '0;
         m_valid_q     <= 1'b0;
         m_reg_write_q <= 1'b0;
         m_rd_q        <= '0;
         m_data_q      <= '0;
         wb_valid_q    <= 1'b0;
         wb_rd_q       <= '0;
         wb_data_q     <= '0;
         rf_q          <= '{default: '0};
         stall_cnt_q   <= '0;
         retire_cnt_q  <= '0;
      end else begin
         d_valid_q     <= d_valid_d;
         d_op_q        <= d_op_d;
         d_mem_read_q  <= d_mem_read_d;
         d_reg_write_q <= d_reg_write_d;
         d_rs_q        <= d_rs_d;
         d_rt_q        <= d_rt_d;
         d_rd_q        <= d_rd_d;
         d_imm_q       <= d_imm_d;
         x_valid_q     <= x_valid_d;
         x_load_q      <= x_load_d;
         x_reg_write_q <= x_reg_write_d;
         x_rd_q        <= x_rd_d;
         x_data_q      <= x_data_d;
         m_valid_q     <= m_valid_d;
         m_reg_write_q <= m_reg_write_d;
         m_rd_q        <= m_rd_d;
         m_data_q      <= m_data_d;
         wb_valid_q    <= wb_valid_d;
         wb_rd_q       <= wb_rd_d;
         wb_data_q     <= wb_data_d;
         rf_q          <= rf_d;
         stall_cnt_q   <= stall_cnt_d;
         retire_cnt_q  <= retire_cnt_d;
      end
   end

   assign out_valid  = wb_valid_q;
   assign out_rd     = wb_rd_q;
   assign out_data   = wb_data_q;
   assign stall_cnt  = stall_cnt_q;
   assign retire_cnt = retire_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_pipe_alu_hazard_fwd.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_pipe_alu_hazard_fwd
// Description : Randomised and directed bench for pipe_alu_hazard_fwd against
//               an architectural-order reference with a schedule model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pipe_alu_hazard_fwd;

   localparam int W  = 8;
   localparam int RW = 5;

   logic          clk = 1'b0;
   logic          rst;
   logic          sel;
   logic          in_valid;
   logic [1:0]    in_op;
   logic          in_mem_read, in_reg_write;
   logic [RW-1:0] in_rs, in_rt, in_rd;
   logic [W-1:0]  in_imm;
   logic          in_valid_a, in_valid_b;

   logic          a_ready, a_ov, b_ready, b_ov;
   logic [RW-1:0] a_rd, b_rd;
   logic [W-1:0]  a_data, b_data;
   logic [15:0]   a_stall, a_ret;
   logic [2:0]    b_stall, b_ret;

   logic          cur_ready, cur_ov;
   logic [RW-1:0] cur_rd;
   logic [W-1:0]  cur_data;
   logic [15:0]   cur_stall, cur_ret;

   always #5 clk = ~clk;

   assign in_valid_a = in_valid && !sel;
   assign in_valid_b = in_valid && sel;
   assign cur_ready  = sel ? b_ready : a_ready;
   assign cur_ov     = sel ? b_ov    : a_ov;
   assign cur_rd     = sel ? b_rd    : a_rd;
   assign cur_data   = sel ? b_data  : a_data;
   assign cur_stall  = sel ? {13'd0, b_stall} : a_stall;
   assign cur_ret    = sel ? {13'd0, b_ret}   : a_ret;

   pipe_alu_hazard_fwd #(.W(W), .RW(RW), .CW(16), .FWD_EN(1'b1)) u_dut_fwd (
      .clk(clk), .rst(rst), .in_valid(in_valid_a), .in_ready(a_ready),
      .in_op(in_op), .in_mem_read(in_mem_read), .in_reg_write(in_reg_write),
      .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd), .in_imm(in_imm),
      .out_valid(a_ov), .out_rd(a_rd), .out_data(a_data),
      .stall_cnt(a_stall), .retire_cnt(a_ret)
   );

   pipe_alu_hazard_fwd #(.W(W), .RW(RW), .CW(3), .FWD_EN(1'b0)) u_dut_nofwd (
      .clk(clk), .rst(rst), .in_valid(in_valid_b), .in_ready(b_ready),
      .in_op(in_op), .in_mem_read(in_mem_read), .in_reg_write(in_reg_write),
      .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd), .in_imm(in_imm),
      .out_valid(b_ov), .out_rd(b_rd), .out_data(b_data),
      .stall_cnt(b_stall), .retire_cnt(b_ret)
   );

   // Reference: results in program order; each instruction's X-entry edge is the
   // earliest edge at which all its sources are available under the forwarding mode.
   typedef struct {
      int            t;
      logic [RW-1:0] rd;
      logic [W-1:0]  d;
   } ret_t;

   int            n_tests = 0;
   int            n_fail  = 0;
   int            cyc     = 0;
   logic [W-1:0]  arch    [32];
   int            avail   [32];
   logic [W-1:0]  ret_val [32];
   ret_t          rq [$];
   int            pend_e, exp_stall, exp_ret, cmax;
   bit            fwd, acc;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d (edge %0d)", tag, got, exp, cyc);
      end
   endtask

   function automatic int sat(input int v);
      return (v > cmax) ? cmax : v;
   endfunction

   task automatic model_reset();
      for (int i = 0; i < 32; i++) begin
         arch[i]    = '0;
         avail[i]   = 0;
         ret_val[i] = 8'hAA;
      end
      rq.delete();
      pend_e    = 0;
      exp_stall = 0;
      exp_ret   = 0;
   endtask

   task automatic check_outputs();
      bit ev;
      ev = (rq.size() > 0) && (rq[0].t == cyc);
      check("out_valid", cur_ov, ev);
      if (ev) begin
         check("out_rd", cur_rd, rq[0].rd);
         check("out_data", cur_data, rq[0].d);
         ret_val[rq[0].rd] = cur_data;
         exp_ret = sat(exp_ret + 1);
         void'(rq.pop_front());
      end
      check("stall_cnt", cur_stall, exp_stall);
      check("retire_cnt", cur_ret, exp_ret);
   endtask

   task automatic step(input bit do_rst, input bit v, input logic [1:0] op,
                       input bit mr, input bit rw, input logic [RW-1:0] rs,
                       input logic [RW-1:0] rt, input logic [RW-1:0] rd,
                       input logic [W-1:0] imm);
      int           k, e, lat;
      bit           er;
      logic [W-1:0] a, b, res;
      ret_t         r;
      k  = cyc + 1;
      er = (k >= pend_e);
      check("in_ready", cur_ready, er);
      rst = !do_rst;
      in_valid = v; in_op = op; in_mem_read = mr; in_reg_write = rw;
      in_rs = rs; in_rt = rt; in_rd = rd; in_imm = imm;
      acc = 1'b0;
      if (do_rst) begin
         model_reset();
      end else begin
         if (!er) exp_stall = sat(exp_stall + 1);
         if (v && er) begin
            acc = 1'b1;
            a = arch[rs];
            b = arch[rt];
            if (mr) res = imm;
            else case (op)
               2'd0:    res = a + b;
               2'd1:    res = a - b;
               2'd2:    res = a & b;
               default: res = imm;
            endcase
            e = k + 1;
            if (rs != 0 && avail[rs] > e) e = avail[rs];
            if (rt != 0 && avail[rt] > e) e = avail[rt];
            if (rw && rd != 0) begin
               arch[rd] = res;
               lat = fwd ? (mr ? 2 : 1) : 3;
               if (e + lat > avail[rd]) avail[rd] = e + lat;
            end
            r.t = e + 2; r.rd = rd; r.d = res;
            rq.push_back(r);
            pend_e = e;
         end
      end
      @(posedge clk);
      cyc++;
      @(negedge clk);
      check_outputs();
   endtask

   // Reset with no pre-edge handshake check (DUT state may be unknown beforehand).
   task automatic cold_reset();
      rst = 1'b0; in_valid = 1'b0; in_op = '0; in_mem_read = 1'b0;
      in_reg_write = 1'b0; in_rs = '0; in_rt = '0; in_rd = '0; in_imm = '0;
      @(posedge clk);
      cyc++;
      model_reset();
      @(negedge clk);
      check_outputs();
   endtask

   task automatic issue(input logic [1:0] op, input bit mr, input bit rw,
                        input logic [RW-1:0] rs, input logic [RW-1:0] rt,
                        input logic [RW-1:0] rd, input logic [W-1:0] imm);
      for (int i = 0; i < 8; i++) begin
         step(1'b0, 1'b1, op, mr, rw, rs, rt, rd, imm);
         if (acc) return;
      end
      check("issue_timeout", 32'd0, 32'd1);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1'b0, 1'b0, 2'd0, 1'b0, 1'b0, '0, '0, '0, '0);
   endtask

   task automatic li(input logic [RW-1:0] rd, input logic [W-1:0] imm);
      issue(2'd3, 1'b0, 1'b1, '0, '0, rd, imm);
   endtask

   task automatic alu(input logic [1:0] op, input logic [RW-1:0] rd,
                      input logic [RW-1:0] rs, input logic [RW-1:0] rt);
      issue(op, 1'b0, 1'b1, rs, rt, rd, '0);
   endtask

   task automatic random_run(input int n);
      for (int i = 0; i < n; i++)
         step(1'b0, $urandom_range(0, 3) != 0, 2'($urandom_range(0, 3)),
              $urandom_range(0, 3) == 0, $urandom_range(0, 7) != 0,
              5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
              5'($urandom_range(0, 7)), 8'($urandom));
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      sel = 1'b0; fwd = 1'b1; cmax = 65535;
      cold_reset();
      cold_reset();

      // Forwarding from X and M, no stalls
      li(5'd1, 8'd10);
      li(5'd2, 8'd15);
      alu(2'd0, 5'd3, 5'd1, 5'd2);
      idle(6);
      check("fwd_add_r3", ret_val[3], 32'd25);
      check("fwd_no_stall", cur_stall, 32'd0);

      // Load-use costs one stall and forwards from M
      issue(2'd0, 1'b1, 1'b1, '0, '0, 5'd9, 8'd30);
      alu(2'd0, 5'd11, 5'd9, 5'd10);
      idle(6);
      check("loaduse_r11", ret_val[11], 32'd30);
      check("loaduse_stall", cur_stall, 32'd1);

      // Register zero
      li(5'd0, 8'd7);
      alu(2'd0, 5'd4, 5'd0, 5'd0);
      idle(6);
      check("r0_add", ret_val[4], 32'd0);
      check("r0_no_stall", cur_stall, 32'd1);

      // Modulo arithmetic
      li(5'd1, 8'd200);
      li(5'd2, 8'd100);
      alu(2'd0, 5'd3, 5'd1, 5'd2);
      alu(2'd1, 5'd5, 5'd2, 5'd1);
      alu(2'd2, 5'd6, 5'd1, 5'd2);
      idle(6);
      check("wrap_add", ret_val[3], 32'd44);
      check("wrap_sub", ret_val[5], 32'd156);
      check("wrap_and", ret_val[6], 32'd64);

      random_run(400);
      idle(6);

      // Reset while a load-use stall is pending
      issue(2'd0, 1'b1, 1'b1, '0, '0, 5'd9, 8'd30);
      step(1'b0, 1'b1, 2'd0, 1'b0, 1'b1, 5'd9, 5'd10, 5'd11, '0);
      step(1'b1, 1'b0, 2'd0, 1'b0, 1'b0, '0, '0, '0, '0);
      check("rst_stall_cleared", cur_stall, 32'd0);
      alu(2'd0, 5'd3, 5'd1, 5'd2);
      idle(6);
      check("post_rst_add", ret_val[3], 32'd0);

      // No-forwarding instance with narrow saturating counters
      sel = 1'b1; fwd = 1'b0; cmax = 7;
      cold_reset();
      li(5'd1, 8'd5);
      alu(2'd0, 5'd2, 5'd1, 5'd1);
      idle(6);
      check("nofwd_r2", ret_val[2], 32'd10);
      check("nofwd_stall2", cur_stall, 32'd2);
      li(5'd5, 8'd3);
      li(5'd6, 8'd4);
      alu(2'd0, 5'd7, 5'd5, 5'd5);
      idle(6);
      check("nofwd_gap_r7", ret_val[7], 32'd6);
      check("nofwd_gap_stall", cur_stall, 32'd3);

      random_run(400);
      idle(6);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/pipe_alu_hazard_fwd.md
# pipe_alu_hazard_fwd

Parametrised 4-stage integer pipeline (D, X, M, W) with internal register file, operand forwarding and load-use hazard stalls. Successor to the fixed 8-bit hazard-only arithmetic pipeline. It adds configurable data width, register count and forwarding mode, a valid/ready issue handshake and saturating stall/retire counters. It sits between the instruction source and the writeback/trace logic.

## Interface
- W, 8: data width.
- RW, 5: register index width; register file has 2^RW entries.
- CW, 16: stall/retire counter width.
- FWD_EN, 1: 1 = forward from X and M stages; 0 = no forwarding, stall on any RAW hazard.
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-low.
- in_valid  in  1  instruction offered.
- in_ready  out  1  instruction accepted when in_valid && in_ready at posedge.
- in_op  in  2  00 add, 01 sub, 10 and, 11 load-immediate (result = in_imm).
- in_mem_read  in  1  load: result = in_imm, available only from M stage; overrides in_op.
- in_reg_write  in  1  instruction writes rd.
- in_rs, in_rt, in_rd  in  RW each  source/destination indices.
- in_imm  in  W  immediate / modelled memory data.
- out_valid  out  1  instruction retired this cycle (W stage valid).
- out_rd  out  RW  retired destination.
- out_data  out  W  retired result.
- stall_cnt  out  CW  cycles D held due to hazard, saturating.
- retire_cnt  out  CW  retired instructions, saturating.

## Operation
- Stages: D (accepted instr, operands not yet resolved), X (ALU), M (load data valid), W (output register). Regfile written at the M->W edge when reg_write && rd != 0.
- Operand resolution at the D->X edge, priority: X-stage non-load result, then M-stage result (ALU or load), then regfile. A source is a match only if the producer is valid, reg_write=1 and rd == src != 0.
- Hazard, FWD_EN=1: instr in D reads (rs or rt) matching rd of a valid load in X.
- Hazard, FWD_EN=0: instr in D reads a register matching any valid writer in X or M.
- On hazard: D holds, a bubble (valid=0) enters X, X/M/W advance normally, and stall_cnt increments.
- in_ready = !(D_valid && hazard); it depends only on state, never on in_valid.
- No backpressure downstream: X, M and W always advance.
- Register 0 reads 0, writes to it are ignored, and it is never a hazard source.
- Arithmetic is modulo 2^W: add and sub wrap, and is bitwise. No flags.
- Non-writing instructions (reg_write=0) still retire with out_valid=1 and their computed out_data.

## Timing
- Reset (rst=0 at posedge) clears:
  - all stage valids to 0 (including a pending stall; the held instr is discarded);
  - regfile to 0;
  - out_valid, out_rd, out_data, stall_cnt, retire_cnt to 0.
  - in_ready = 1 the cycle after reset.
- Latency: instr accepted at edge E0 is in D after E0, X after E1, M after E2, W after E3. out_valid is high for exactly one cycle following E3, 3 cycles after accept with no stall. Each stall cycle adds 1.
- Throughput: 1 instr/cycle without hazards.
- Load-use with FWD_EN=1 costs exactly 1 stall. A load two instructions ahead forwards from M with no stall.
- FWD_EN=0:
  - dependent instr immediately after its producer stalls 2 cycles;
  - one instr gap stalls 1 cycle;
  - two or more instrs gap: no stall.
- Counters saturate at 2^CW-1 and never wrap.
- Simultaneous X and M match on the same register: X wins (youngest producer).

## Test plan
- FWD_EN=1, W=8, back-to-back li r1=10, li r2=15, add r3=r1+r2 -> r3 retires 25; stall_cnt=0; in_ready never drops.
- Load r9 imm=30, then add r11=r9+r10 (r10=0) -> in_ready low exactly 1 cycle; stall_cnt=1; r11 retires 30, 5 cycles after load accept.
- FWD_EN=0, li r1=5, then add r2=r1+r1 -> 2 stall cycles; r2 retires 10; stall_cnt=2.
- li r0=7, then add r4=r0+r0 -> r4 retires 0; no stall; r0 stays 0.
- Wrap: li r1=200, li r2=100, add r3=r1+r2 -> 44; sub r5=r2-r1 -> 156; and r6=r1&r2 -> 64.
- Assert rst=0 during a load-use stall -> next cycle all valids 0, in_ready=1, counters 0. A post-reset add r3=r1+r2 retires 0.
